serpent_stream_if: RTL and testbench

Stream front/back end for the Serpent core: packs four 32-bit input words into one 128-bit block, drives the core's key/data/valid inputs, and captures the 128-bit result. It then serialises the result as four 32-bit words on a valid/ready output stream. It sits directly between the system bus bridge and `serpent_top`, so the core only ever sees stable, fully assembled blocks.

---
 rtl/serpent_stream_if.sv | 248 ++++++++++++++++++++++++
 tb/tb_serpent_stream_if.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serpent_stream_if.sv
// serpent_stream_if: word-stream front/back end for the Serpent core.
// Packs four 32-bit input words (MSW first) into a 128-bit block, hands it to
// the core with a stable key, captures the 128-bit result and streams it back
// out as four 32-bit words (MSW first) on a valid/ready interface.
// Optional build macro: SERPENT_IF_TIMEOUT_EN enables the WAIT-state timeout
// counter and the sticky o_err flag; without it o_err is tied low.
module serpent_stream_if #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic         i_clk,
    input  logic         i_rstn,
    input  logic [255:0] i_key,
    input  logic         i_key_load,
    output logic         o_key_loaded,
    input  logic         i_mode,
    input  logic [31:0]  i_s_data,
    input  logic         i_s_valid,
    output logic         o_s_ready,
    output logic [255:0] o_core_key,
    output logic [127:0] o_core_data,
    output logic         o_core_key_valid,
    output logic         o_core_ena_en_de,
    input  logic [127:0] i_core_data,
    input  logic         i_core_data_valid,
    output logic [31:0]  o_m_data,
    output logic         o_m_valid,
    input  logic         i_m_ready,
    output logic         o_busy,
    output logic         o_err,
    input  logic         i_err_clr
);

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t         state_r,      state_s;
    logic [1:0]     cnt_r,        cnt_s;         // fill word count / drain word index
    logic [255:0]   key_r,        key_s;
    logic           key_loaded_r, key_loaded_s;
    logic [127:0]   core_data_r,  core_data_s;
    logic           ena_r,        ena_s;
    logic           key_valid_r,  key_valid_s;
    logic [127:0]   res_r,        res_s;
    logic [31:0]    m_data_r,     m_data_s;
    logic           m_valid_r,    m_valid_s;
    logic           s_ready_r,    s_ready_s;
    logic           busy_r,       busy_s;
    logic           err_r,        err_s;

`ifdef SERPENT_IF_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST_C = 16'(TIMEOUT_CYCLES - 32'd1);
    logic [15:0]    tmo_r,        tmo_s;
`else
    logic [16:0]    unused_cfg_s;
    assign unused_cfg_s = {i_err_clr, TIMEOUT_CYCLES[15:0]};
`endif

    // Select 32-bit word idx of a block, word 0 being the most significant.
    function automatic logic [31:0] word_sel(input logic [127:0] blk, input logic [1:0] idx);
        logic [31:0] w;
        case (idx)
            2'd0:    w = blk[127:96];
            2'd1:    w = blk[95:64];
            2'd2:    w = blk[63:32];
            2'd3:    w = blk[31:0];
            default: w = 32'd0;
        endcase
        return w;
    endfunction

    // Replace word idx of a block, word 0 being the most significant.
    function automatic logic [127:0] put_word(input logic [127:0] blk, input logic [1:0] idx,
                                              input logic [31:0] w);
        logic [127:0] r;
        r = blk;
        case (idx)
            2'd0:    r[127:96] = w;
            2'd1:    r[95:64]  = w;
            2'd2:    r[63:32]  = w;
            2'd3:    r[31:0]   = w;
            default: r = blk;
        endcase
        return r;
    endfunction

    // Next-state and next-output computation for the FILL/ISSUE/WAIT/DRAIN sequencer.
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        key_s        = key_r;
        key_loaded_s = key_loaded_r;
        core_data_s  = core_data_r;
        ena_s        = ena_r;
        key_valid_s  = key_valid_r;
        res_s        = res_r;
        m_data_s     = m_data_r;
        m_valid_s    = m_valid_r;
`ifdef SERPENT_IF_TIMEOUT_EN
        tmo_s        = 16'd0;
        if (i_err_clr) begin
            err_s = 1'b0;
        end else begin
            err_s = err_r;
        end
`else
        err_s        = 1'b0;
`endif

        case (state_r)
            ST_FILL: begin
                // Key may only change between blocks so the core never sees it move.
                if (i_key_load && (cnt_r == 2'd0)) begin
                    key_s        = i_key;
                    key_loaded_s = 1'b1;
                end else begin
                    key_s        = key_r;
                end
                if (i_s_valid && s_ready_r) begin
                    core_data_s = put_word(core_data_r, cnt_r, i_s_data);
                    if (cnt_r == 2'd0) begin
                        ena_s = i_mode;
                    end else begin
                        ena_s = ena_r;
                    end
                    if (cnt_r == 2'd3) begin
                        state_s = ST_ISSUE;
                        cnt_s   = 2'd0;
                    end else begin
                        cnt_s   = cnt_r + 2'd1;
                    end
                end else begin
                    cnt_s = cnt_r;
                end
            end
            ST_ISSUE: begin
                // A result level still high from the previous block must drain first.
                if (!i_core_data_valid) begin
                    key_valid_s = 1'b1;
                    state_s     = ST_WAIT;
                end else begin
                    key_valid_s = 1'b0;
                end
            end
            ST_WAIT: begin
                if (i_core_data_valid) begin
                    res_s       = i_core_data;
                    m_data_s    = i_core_data[127:96];
                    m_valid_s   = 1'b1;
                    key_valid_s = 1'b0;
                    cnt_s       = 2'd0;
                    state_s     = ST_DRAIN;
                end else begin
`ifdef SERPENT_IF_TIMEOUT_EN
                    if (tmo_r == TMO_LAST_C) begin
                        err_s       = 1'b1;
                        key_valid_s = 1'b0;
                        cnt_s       = 2'd0;
                        state_s     = ST_FILL;
                    end else begin
                        tmo_s       = tmo_r + 16'd1;
                    end
`else
                    key_valid_s = 1'b1;
`endif
                end
            end
            ST_DRAIN: begin
                if (i_m_ready) begin
                    if (cnt_r == 2'd3) begin
                        m_valid_s = 1'b0;
                        m_data_s  = 32'd0;
                        cnt_s     = 2'd0;
                        state_s   = ST_FILL;
                    end else begin
                        cnt_s     = cnt_r + 2'd1;
                        m_data_s  = word_sel(res_r, cnt_r + 2'd1);
                    end
                end else begin
                    m_data_s = m_data_r;
                end
            end
            default: begin
                state_s     = ST_FILL;
                cnt_s       = 2'd0;
                key_valid_s = 1'b0;
                m_valid_s   = 1'b0;
            end
        endcase

        s_ready_s = (state_s == ST_FILL) && key_loaded_s;
        busy_s    = !((state_s == ST_FILL) && (cnt_s == 2'd0));
    end

    // State and output registers; every port output is driven from here.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_r      <= ST_FILL;
            cnt_r        <= 2'd0;
            key_r        <= 256'd0;
            key_loaded_r <= 1'b0;
            core_data_r  <= 128'd0;
            ena_r        <= 1'b0;
            key_valid_r  <= 1'b0;
            res_r        <= 128'd0;
            m_data_r     <= 32'd0;
            m_valid_r    <= 1'b0;
            s_ready_r    <= 1'b0;
            busy_r       <= 1'b0;
            err_r        <= 1'b0;
`ifdef SERPENT_IF_TIMEOUT_EN
            tmo_r        <= 16'd0;
`endif
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            key_r        <= key_s;
            key_loaded_r <= key_loaded_s;
            core_data_r  <= core_data_s;
            ena_r        <= ena_s;
            key_valid_r  <= key_valid_s;
            res_r        <= res_s;
            m_data_r     <= m_data_s;
            m_valid_r    <= m_valid_s;
            s_ready_r    <= s_ready_s;
            busy_r       <= busy_s;
            err_r        <= err_s;
`ifdef SERPENT_IF_TIMEOUT_EN
            tmo_r        <= tmo_s;
`endif
        end
    end

    assign o_key_loaded     = key_loaded_r;
    assign o_s_ready        = s_ready_r;
    assign o_core_key       = key_r;
    assign o_core_data      = core_data_r;
    assign o_core_key_valid = key_valid_r;
    assign o_core_ena_en_de = ena_r;
    assign o_m_data         = m_data_r;
    assign o_m_valid        = m_valid_r;
    assign o_busy           = busy_r;
    assign o_err            = err_r;

endmodule

// File: tb/tb_serpent_stream_if.sv
// Self-checking bench for serpent_stream_if: table of blocks with a toy
// invertible core model, scoreboard of expected output words, and hand-written
// sequences for no-key, late-key, reset-mid-block and (when built with
// SERPENT_IF_TIMEOUT_EN) timeout behaviour.
`timescale 1ns/1ps
module tb_serpent_stream_if;

    logic         i_clk = 1'b0;
    logic         i_rstn;
    logic [255:0] i_key;
    logic         i_key_load;
    logic         o_key_loaded;
    logic         i_mode;
    logic [31:0]  i_s_data;
    logic         i_s_valid;
    logic         o_s_ready;
    logic [255:0] o_core_key;
    logic [127:0] o_core_data;
    logic         o_core_key_valid;
    logic         o_core_ena_en_de;
    logic [127:0] i_core_data;
    logic         i_core_data_valid;
    logic [31:0]  o_m_data;
    logic         o_m_valid;
    logic         i_m_ready;
    logic         o_busy;
    logic         o_err;
    logic         i_err_clr;

    always #5 i_clk = ~i_clk;

    serpent_stream_if #(.TIMEOUT_CYCLES(8)) dut (
        .i_clk(i_clk), .i_rstn(i_rstn), .i_key(i_key), .i_key_load(i_key_load),
        .o_key_loaded(o_key_loaded), .i_mode(i_mode), .i_s_data(i_s_data),
        .i_s_valid(i_s_valid), .o_s_ready(o_s_ready), .o_core_key(o_core_key),
        .o_core_data(o_core_data), .o_core_key_valid(o_core_key_valid),
        .o_core_ena_en_de(o_core_ena_en_de), .i_core_data(i_core_data),
        .i_core_data_valid(i_core_data_valid), .o_m_data(o_m_data), .o_m_valid(o_m_valid),
        .i_m_ready(i_m_ready), .o_busy(o_busy), .o_err(o_err), .i_err_clr(i_err_clr)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int proto_err = 0;

    logic [31:0]  exp_q[$];
    logic [127:0] cur_blk;
    logic         cur_mode;
    int           core_lat  = 3;
    int           core_hold = 0;
    bit           core_en   = 1'b1;
    int           bp_mode   = 0;
    bit           tmo_test  = 1'b0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Toy invertible core: encrypt = rotate-left 32 then xor low key half.
    function automatic logic [127:0] core_fn(input logic [255:0] k, input logic [127:0] d,
                                             input logic m);
        logic [127:0] t;
        if (m) begin
            t = {d[95:0], d[127:96]} ^ k[127:0];
        end else begin
            t = d ^ k[127:0];
            t = {t[31:0], t[127:32]};
        end
        return t;
    endfunction

    // Core model: answer core_lat cycles after key_valid, hold the level core_hold cycles.
    initial begin
        int lat_c;
        int hold_c;
        lat_c = 0;
        hold_c = 0;
        i_core_data_valid = 1'b0;
        i_core_data = 128'd0;
        forever begin
            @(posedge i_clk); #1;
            if (!i_rstn || !core_en) begin
                i_core_data_valid = 1'b0;
                lat_c = 0;
                hold_c = 0;
            end else if (o_core_key_valid && !i_core_data_valid) begin
                if (lat_c >= core_lat) begin
                    chk("core_data", o_core_data, cur_blk);
                    chk("core_mode", o_core_ena_en_de, cur_mode);
                    i_core_data = core_fn(o_core_key, o_core_data, o_core_ena_en_de);
                    i_core_data_valid = 1'b1;
                    lat_c = 0;
                    hold_c = 0;
                end else lat_c++;
            end else if (i_core_data_valid && !o_core_key_valid) begin
                if (hold_c >= core_hold) i_core_data_valid = 1'b0;
                else hold_c++;
            end
        end
    end

    // Output-side ready: 0 = always, 1 = toggle, 2 = random.
    initial begin
        logic tgl;
        tgl = 1'b0;
        i_m_ready = 1'b0;
        forever begin
            @(posedge i_clk); #1;
            case (bp_mode)
                0: i_m_ready = 1'b1;
                1: begin tgl = ~tgl; i_m_ready = tgl; end
                default: i_m_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Output monitor / scoreboard and protocol watch.
    initial begin
        logic pv, pr, pkv, pcv;
        logic [31:0] pd;
        pv = 1'b0; pr = 1'b0; pkv = 1'b0; pcv = 1'b0; pd = 32'd0;
        forever begin
            @(negedge i_clk);
            if (!i_rstn) begin
                pv = 1'b0; pr = 1'b0; pkv = 1'b0; pcv = 1'b0;
            end else begin
                if (pv && !pr) begin
                    chk("m_hold_valid", o_m_valid, 1'b1);
                    chk("m_hold_data", o_m_data, pd);
                end
                if (o_m_valid && o_s_ready) proto_err++;
                if (!pkv && o_core_key_valid && pcv) proto_err++;
                if (pkv && !o_core_key_valid && !pcv && !tmo_test) proto_err++;
                if (o_m_valid && i_m_ready) begin
                    if (exp_q.size() == 0) chk("m_unexpected_word", o_m_data, 32'hx);
                    else chk("m_word", o_m_data, exp_q.pop_front());
                end
                pv = o_m_valid; pr = i_m_ready; pd = o_m_data;
                pkv = o_core_key_valid; pcv = i_core_data_valid;
            end
        end
    end

    task automatic send_word(input logic [31:0] w, input logic m, input bit first);
        logic rd;
        int n;
        n = 0;
        i_s_valid = 1'b1;
        i_s_data = w;
        i_mode = first ? m : ~m;
        do begin
            @(negedge i_clk); rd = o_s_ready;
            @(posedge i_clk); #1;
            n++;
        end while (!rd && n < 200);
        if (!rd) chk("s_accept_timeout", 1'b0, 1'b1);
        i_s_valid = 1'b0;
    endtask

    task automatic send_block(input logic [127:0] blk, input logic m, input logic [127:0] exp,
                              input bit push);
        cur_blk = blk;
        cur_mode = m;
        if (push) for (int i = 0; i < 4; i++) exp_q.push_back(exp[127 - 32*i -: 32]);
        for (int i = 0; i < 4; i++) send_word(blk[127 - 32*i -: 32], m, i == 0);
    endtask

    task automatic load_key(input logic [255:0] k);
        i_key = k;
        i_key_load = 1'b1;
        @(posedge i_clk); #1;
        i_key_load = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin @(posedge i_clk); #1; n++; end
        chk("drain_done", exp_q.size(), 0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_flags"}, {o_key_loaded, o_s_ready, o_core_key_valid, o_core_ena_en_de,
                              o_m_valid, o_busy, o_err}, 7'd0);
        chk({tag, "_core_key"}, o_core_key, 256'd0);
        chk({tag, "_core_data"}, o_core_data, 128'd0);
        chk({tag, "_m_data"}, o_m_data, 32'd0);
    endtask

    typedef struct {
        logic [255:0] key;
        logic [127:0] blk;
        logic         mode;
        logic [127:0] exp;
        int           lat;
        int           hold;
        int           bp;
    } vec_t;

    vec_t vecs[6];
    localparam logic [255:0] KEY_C =
        256'h0123456789ABCDEF0123456789ABCDEF0123456789ABCDEF0123456789ABCDEF;
    localparam logic [127:0] PT_C = 128'hFEDCBA9876543210FEDCBA9876543210;
    localparam logic [127:0] CT_C = 128'h77777777777777777777777777777777;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{KEY_C, PT_C, 1'b1, CT_C, 3, 0, 0};
        vecs[1] = '{KEY_C, CT_C, 1'b0, PT_C, 2, 0, 1};
        for (int i = 2; i < 6; i++) begin
            vecs[i].key  = {$urandom, $urandom, $urandom, $urandom,
                            $urandom, $urandom, $urandom, $urandom};
            vecs[i].blk  = {$urandom, $urandom, $urandom, $urandom};
            vecs[i].mode = 1'(i);
            vecs[i].exp  = core_fn(vecs[i].key, vecs[i].blk, vecs[i].mode);
            vecs[i].lat  = $urandom_range(0, 5);
            vecs[i].hold = (i >= 4) ? 25 : 0;
            vecs[i].bp   = (i == 3 || i == 5) ? 2 : 0;
        end

        i_rstn = 1'b0; i_key = 256'd0; i_key_load = 1'b0; i_mode = 1'b0;
        i_s_data = 32'd0; i_s_valid = 1'b0; i_err_clr = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        chk_zero("reset");
        i_rstn = 1'b1;

        // No key: input must stay blocked.
        i_s_valid = 1'b1;
        repeat (4) begin
            @(negedge i_clk);
            chk("nokey_s_ready", o_s_ready, 1'b0);
        end
        @(posedge i_clk); #1;
        i_s_valid = 1'b0;
        chk("nokey_busy", o_busy, 1'b0);

        // Table of blocks.
        for (int v = 0; v < 6; v++) begin
            core_lat = vecs[v].lat;
            core_hold = vecs[v].hold;
            bp_mode = vecs[v].bp;
            load_key(vecs[v].key);
            chk("key_latched", o_core_key, vecs[v].key);
            send_block(vecs[v].blk, vecs[v].mode, vecs[v].exp, 1'b1);
            wait_drain();
        end
        core_hold = 0;
        bp_mode = 0;
        repeat (30) @(posedge i_clk);
        #1;

        // Late key load while waiting for the core is ignored.
        core_lat = 12;
        load_key(KEY_C);
        send_block(PT_C, 1'b1, CT_C, 1'b1);
        repeat (3) @(posedge i_clk);
        #1;
        chk("late_in_wait", o_core_key_valid, 1'b1);
        i_key = ~KEY_C;
        i_key_load = 1'b1;
        @(posedge i_clk); #1;
        i_key_load = 1'b0;
        chk("late_key_unchanged", o_core_key, KEY_C);
        wait_drain();
        core_lat = 3;

        // Reset after two words discards block and key.
        load_key(KEY_C);
        send_word(32'h11111111, 1'b1, 1'b1);
        send_word(32'h22222222, 1'b1, 1'b0);
        chk("mid_busy", o_busy, 1'b1);
        i_rstn = 1'b0;
        #2;
        chk_zero("midreset");
        @(posedge i_clk); #1;
        i_rstn = 1'b1;
        i_s_valid = 1'b1;
        repeat (3) begin
            @(negedge i_clk);
            chk("post_reset_s_ready", o_s_ready, 1'b0);
        end
        @(posedge i_clk); #1;
        i_s_valid = 1'b0;
        load_key(KEY_C);
        send_block(PT_C, 1'b1, CT_C, 1'b1);
        wait_drain();

`ifdef SERPENT_IF_TIMEOUT_EN
        // Core never answers: flag rises at the 8th WAIT cycle, block is dropped.
        tmo_test = 1'b1;
        core_en = 1'b0;
        send_block(PT_C, 1'b1, CT_C, 1'b0);
        @(posedge i_clk); #1;
        chk("tmo_wait_enter", o_core_key_valid, 1'b1);
        repeat (7) @(posedge i_clk);
        #1;
        chk("tmo_before", {o_err, o_core_key_valid}, 2'b01);
        @(posedge i_clk); #1;
        chk("tmo_fire", {o_err, o_core_key_valid, o_busy, o_s_ready}, 4'b1001);
        i_err_clr = 1'b1;
        @(posedge i_clk); #1;
        i_err_clr = 1'b0;
        chk("tmo_clear", o_err, 1'b0);
        core_en = 1'b1;
        tmo_test = 1'b0;
        send_block(CT_C, 1'b0, PT_C, 1'b1);
        wait_drain();
`else
        i_err_clr = 1'b1;
        @(posedge i_clk); #1;
        i_err_clr = 1'b0;
        chk("err_tied_low", o_err, 1'b0);
`endif

        repeat (5) @(posedge i_clk);
        #1;
        chk("protocol_violations", proto_err, 0);
        chk("end_idle", {o_busy, o_m_valid, o_core_key_valid}, 3'b000);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
